// File: rtl/axi_lite_cfg_sequencer.sv
// AXI4-Lite configuration sequencer: walks a table of {addr, data, mask}
// entries, writes each one to a control slave, and optionally verifies it
// by reading it back. Verify mismatches are retried. Slave errors and
// timeouts abort the sequence and are reported through err_code and err_idx.
module axi_lite_cfg_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int N_CMD     = 8,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 256,
  localparam int IDX_W    = (N_CMD > 1) ? $clog2(N_CMD) : 1
) (
  input  logic              s_axi_ctrl_aclk,
  input  logic              s_axi_ctrl_areset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [IDX_W-1:0]  err_idx,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  input  logic [DATA_W-1:0] tbl_mask,
  output logic              s_axi_ctrl_awvalid,
  input  logic              s_axi_ctrl_awready,
  output logic [ADDR_W-1:0] s_axi_ctrl_awaddr,
  output logic              s_axi_ctrl_wvalid,
  input  logic              s_axi_ctrl_wready,
  output logic [DATA_W-1:0] s_axi_ctrl_wdata,
  input  logic              s_axi_ctrl_bvalid,
  output logic              s_axi_ctrl_bready,
  input  logic [1:0]        s_axi_ctrl_bresp,
  output logic              s_axi_ctrl_arvalid,
  input  logic              s_axi_ctrl_arready,
  output logic [ADDR_W-1:0] s_axi_ctrl_araddr,
  input  logic              s_axi_ctrl_rvalid,
  output logic              s_axi_ctrl_rready,
  input  logic [DATA_W-1:0] s_axi_ctrl_rdata,
  input  logic [1:0]        s_axi_ctrl_rresp
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_B, S_RD, S_R, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t           state, nxt;
  logic [1:0]       err_nxt;
  logic [TMO_W-1:0] tmo;
  logic [RTY_W-1:0] retries;
  logic             armed, aw_done, w_done;
  logic             aw_hs, w_hs, tmo_hit, verify_ok;

  assign aw_hs     = s_axi_ctrl_awvalid & s_axi_ctrl_awready;
  assign w_hs      = s_axi_ctrl_wvalid & s_axi_ctrl_wready;
  assign tmo_hit   = (tmo == TMO_W'(TIMEOUT - 1));
  assign verify_ok = ((s_axi_ctrl_rdata ^ s_axi_ctrl_wdata) & tbl_mask) == '0;
  assign s_axi_ctrl_araddr = s_axi_ctrl_awaddr;

  // State register
  always_ff @(posedge s_axi_ctrl_aclk) begin
    if (s_axi_ctrl_areset) state <= S_IDLE;
    else                   state <= nxt;
  end

  // Next-state decode, including the error code for any transition to ERROR
  always_comb begin
    nxt     = state;
    err_nxt = 2'd0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) nxt = S_WR;
      S_WR: begin
        if (armed && (aw_done || aw_hs) && (w_done || w_hs)) nxt = S_B;
        else if (tmo_hit) begin nxt = S_ERROR; err_nxt = 2'd3; end
      end
      S_B: begin
        if (s_axi_ctrl_bvalid) begin
          if (s_axi_ctrl_bresp != 2'b00) begin nxt = S_ERROR; err_nxt = 2'd2; end
          else if (tbl_mask != '0)        nxt = S_RD;
          else                            nxt = S_NEXT;
        end else if (tmo_hit) begin nxt = S_ERROR; err_nxt = 2'd3; end
      end
      S_RD: begin
        if (s_axi_ctrl_arready) nxt = S_R;
        else if (tmo_hit) begin nxt = S_ERROR; err_nxt = 2'd3; end
      end
      S_R: begin
        if (s_axi_ctrl_rvalid) begin
          if (s_axi_ctrl_rresp != 2'b00) begin nxt = S_ERROR; err_nxt = 2'd2; end
          else if (verify_ok)                     nxt = S_NEXT;
          else if (retries < RTY_W'(MAX_RETRY))   nxt = S_WR;
          else begin nxt = S_ERROR; err_nxt = 2'd1; end
        end else if (tmo_hit) begin nxt = S_ERROR; err_nxt = 2'd3; end
      end
      S_NEXT: nxt = (tbl_idx == IDX_W'(N_CMD - 1)) ? S_DONE : S_WR;
      default: nxt = S_IDLE;
    endcase
  end

  // Datapath: table index, retries, timeout, write-channel progress, error capture.
  // tbl_idx only advances on the NEXT->WR edge, so the table output for the new
  // index is first valid inside WR; the first WR cycle latches awaddr/wdata
  // (armed) and the valids rise on the following cycle.
  always_ff @(posedge s_axi_ctrl_aclk) begin
    if (s_axi_ctrl_areset) begin
      tmo               <= '0;
      retries           <= '0;
      tbl_idx           <= '0;
      err_code          <= '0;
      err_idx           <= '0;
      armed             <= 1'b0;
      aw_done           <= 1'b0;
      w_done            <= 1'b0;
      s_axi_ctrl_awaddr <= '0;
      s_axi_ctrl_wdata  <= '0;
    end else begin
      if (nxt != state)  tmo <= '0;
      else if (!tmo_hit) tmo <= tmo + 1'b1;

      if ((state == S_IDLE || state == S_DONE || state == S_ERROR) && start) begin
        err_code <= '0;
        err_idx  <= '0;
        tbl_idx  <= '0;
        retries  <= '0;
      end
      if (state == S_NEXT && nxt == S_WR) begin
        tbl_idx <= tbl_idx + 1'b1;
        retries <= '0;
      end
      if (state == S_R && nxt == S_WR) retries <= retries + 1'b1;
      if (nxt == S_ERROR && state != S_ERROR) begin
        err_code <= err_nxt;
        err_idx  <= tbl_idx;
      end

      if (nxt == S_WR && state != S_WR) begin
        armed   <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (state == S_WR) begin
        if (!armed) begin
          armed             <= 1'b1;
          s_axi_ctrl_awaddr <= tbl_addr;
          s_axi_ctrl_wdata  <= tbl_data;
        end
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
    end
  end

  // Output decode from state and channel progress flags
  always_comb begin
    busy               = (state == S_WR) || (state == S_B) || (state == S_RD) ||
                         (state == S_R)  || (state == S_NEXT);
    done               = (state == S_DONE);
    error              = (state == S_ERROR);
    s_axi_ctrl_awvalid = (state == S_WR) && armed && !aw_done;
    s_axi_ctrl_wvalid  = (state == S_WR) && armed && !w_done;
    s_axi_ctrl_bready  = (state == S_B);
    s_axi_ctrl_arvalid = (state == S_RD);
    s_axi_ctrl_rready  = (state == S_R);
  end

endmodule

// File: tb/tb_axi_lite_cfg_sequencer.sv
// Directed bench for axi_lite_cfg_sequencer with a configurable echo slave.
module tb_axi_lite_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [2:0]  err_idx, tbl_idx;
  logic [7:0]  tbl_addr;
  logic [31:0] tbl_data, tbl_mask;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [7:0]  awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int failures = 0;

  // slave knobs
  int          aw_delay = 0;
  logic        b_never = 1'b0;
  logic        corrupt_en = 1'b0;
  logic [7:0]  corrupt_addr = 8'h00;
  logic        bresp_en = 1'b0;
  logic [7:0]  bresp_addr = 8'h00;
  logic        log_clr = 1'b0;

  // slave state and logs
  logic [31:0] mem [64];
  int          wr_cnt [64];
  int          rd_cnt [64];
  logic [7:0]  wr_seq [32];
  int          wr_n;
  int          aw_cnt;
  logic        got_aw, got_w, pend_b, rv;
  logic [7:0]  aw_addr_q, b_addr, addr_now;
  logic [31:0] w_data_q, data_now, rdata_q;
  logic        commit;

  always #5 clk = ~clk;

  axi_lite_cfg_sequencer #(.ADDR_W(8), .DATA_W(32), .N_CMD(8), .MAX_RETRY(2), .TIMEOUT(16)) dut (
    .s_axi_ctrl_aclk(clk), .s_axi_ctrl_areset(rst), .start(start),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .err_idx(err_idx),
    .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_mask(tbl_mask),
    .s_axi_ctrl_awvalid(awvalid), .s_axi_ctrl_awready(awready), .s_axi_ctrl_awaddr(awaddr),
    .s_axi_ctrl_wvalid(wvalid), .s_axi_ctrl_wready(wready), .s_axi_ctrl_wdata(wdata),
    .s_axi_ctrl_bvalid(bvalid), .s_axi_ctrl_bready(bready), .s_axi_ctrl_bresp(bresp),
    .s_axi_ctrl_arvalid(arvalid), .s_axi_ctrl_arready(arready), .s_axi_ctrl_araddr(araddr),
    .s_axi_ctrl_rvalid(rvalid), .s_axi_ctrl_rready(rready), .s_axi_ctrl_rdata(rdata),
    .s_axi_ctrl_rresp(rresp)
  );

  function automatic logic [7:0] exp_addr(input int i);
    return 8'h10 + 8'(i * 4);
  endfunction

  // Command table: entry 7 skips readback
  always_comb begin
    tbl_addr = exp_addr(int'(tbl_idx));
    tbl_data = 32'hA500_0000 | (32'(tbl_idx) * 32'h111);
    tbl_mask = (tbl_idx == 3'd7) ? 32'h0 : 32'hFFFF_FFFF;
  end

  assign awready  = awvalid && (aw_cnt >= aw_delay);
  assign wready   = 1'b1;
  assign addr_now = (awvalid && awready) ? awaddr : aw_addr_q;
  assign data_now = (wvalid && wready) ? wdata : w_data_q;
  assign commit   = (got_aw || (awvalid && awready)) && (got_w || (wvalid && wready)) && !pend_b;
  assign bvalid   = pend_b && !b_never;
  assign bresp    = (bresp_en && b_addr == bresp_addr) ? 2'b10 : 2'b00;
  assign arready  = !rv;
  assign rvalid   = rv;
  assign rdata    = rdata_q;
  assign rresp    = 2'b00;

  // Echo slave with write/read logging
  always @(posedge clk) begin
    if (rst || log_clr) begin
      for (int i = 0; i < 64; i++) begin
        mem[i] <= 32'h0; wr_cnt[i] <= 0; rd_cnt[i] <= 0;
      end
      for (int i = 0; i < 32; i++) wr_seq[i] <= 8'h00;
      wr_n <= 0; aw_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0; pend_b <= 1'b0;
      rv <= 1'b0; aw_addr_q <= 8'h00; w_data_q <= 32'h0; b_addr <= 8'h00; rdata_q <= 32'h0;
    end else begin
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
      else                     aw_cnt <= 0;
      if (commit) begin
        mem[addr_now[7:2]]    <= data_now;
        wr_cnt[addr_now[7:2]] <= wr_cnt[addr_now[7:2]] + 1;
        if (wr_n < 32) wr_seq[wr_n] <= addr_now;
        wr_n   <= wr_n + 1;
        pend_b <= 1'b1;
        b_addr <= addr_now;
        got_aw <= 1'b0;
        got_w  <= 1'b0;
      end else begin
        if (awvalid && awready) begin got_aw <= 1'b1; aw_addr_q <= awaddr; end
        if (wvalid && wready)   begin got_w <= 1'b1;  w_data_q <= wdata;   end
      end
      if (bvalid && bready) pend_b <= 1'b0;
      if (arvalid && arready) begin
        rv      <= 1'b1;
        rdata_q <= mem[araddr[7:2]] ^ ((corrupt_en && araddr == corrupt_addr) ? 32'h1 : 32'h0);
        rd_cnt[araddr[7:2]] <= rd_cnt[araddr[7:2]] + 1;
      end else if (rv && rready) begin
        rv <= 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_log();
    @(negedge clk); log_clr = 1'b1;
    @(negedge clk); log_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int c;
    for (c = 0; c < 3000; c++) begin
      if (done || error) break;
      @(negedge clk);
    end
    checks++;
    if (!(done || error)) begin
      failures++;
      $display("FAIL %s_wait: done/error never rose within 3000 cycles", name);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, done, error, err_code, err_idx, tbl_idx} !== 11'b0) begin
      failures++;
      $display("FAIL reset_status: got %b required 0", {busy, done, error, err_code, err_idx, tbl_idx});
    end
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, awaddr, araddr, wdata} !== 53'b0) begin
      failures++;
      $display("FAIL reset_bus: got %h required 0", {awvalid, wvalid, bready, arvalid, rready, awaddr, araddr, wdata});
    end
  endtask

  task automatic test_basic();
    int bad_order;
    int reads;
    clear_log();
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy: got %b required 1", busy);
    end
    wait_end("basic");
    checks++;
    if ({done, error, err_code, busy} !== 5'b10000) begin
      failures++;
      $display("FAIL basic_status: done,error,err_code,busy got %b required 10000", {done, error, err_code, busy});
    end
    checks++;
    if (wr_n !== 8) begin
      failures++;
      $display("FAIL basic_writes: got %0d required 8", wr_n);
    end
    bad_order = 0;
    for (int i = 0; i < 8; i++) if (wr_seq[i] !== exp_addr(i)) bad_order++;
    checks++;
    if (bad_order != 0) begin
      failures++;
      $display("FAIL basic_order: %0d entries out of address order, required 0", bad_order);
    end
    reads = 0;
    for (int i = 0; i < 64; i++) reads += rd_cnt[i];
    checks++;
    if (reads != 7 || rd_cnt[exp_addr(7) >> 2] != 0) begin
      failures++;
      $display("FAIL basic_reads: got %0d (entry7 %0d) required 7 (entry7 0)", reads, rd_cnt[exp_addr(7) >> 2]);
    end
    checks++;
    if (mem[exp_addr(5) >> 2] !== 32'hA500_0555) begin
      failures++;
      $display("FAIL basic_data: got %h required a5000555", mem[exp_addr(5) >> 2]);
    end
  endtask

  task automatic test_aw_delay();
    int aw_n;
    int w_n;
    int c;
    int once_bad;
    aw_delay = 2;
    clear_log();
    pulse_start();
    for (c = 0; c < 50 && !awvalid; c++) @(negedge clk);
    aw_n = 0; w_n = 0;
    for (c = 0; c < 20; c++) begin
      if (!awvalid && !wvalid) break;
      if (awvalid) aw_n++;
      if (wvalid)  w_n++;
      @(negedge clk);
    end
    checks++;
    if (aw_n != 3 || w_n != 1) begin
      failures++;
      $display("FAIL awdelay_valids: awvalid %0d wvalid %0d cycles, required 3 and 1", aw_n, w_n);
    end
    wait_end("awdelay");
    once_bad = 0;
    for (int i = 0; i < 8; i++) if (wr_cnt[exp_addr(i) >> 2] != 1) once_bad++;
    checks++;
    if (once_bad != 0 || done !== 1'b1) begin
      failures++;
      $display("FAIL awdelay_once: %0d entries not written once, done %b; required 0 and 1", once_bad, done);
    end
    aw_delay = 0;
  endtask

  task automatic test_retry();
    corrupt_en = 1'b1; corrupt_addr = exp_addr(2);
    clear_log();
    pulse_start();
    wait_end("retry");
    checks++;
    if ({error, done, err_code, err_idx} !== 7'b1001010) begin
      failures++;
      $display("FAIL retry_status: error,done,code,idx got %b required 1001010", {error, done, err_code, err_idx});
    end
    checks++;
    if (wr_cnt[exp_addr(2) >> 2] != 3 || wr_cnt[exp_addr(3) >> 2] != 0) begin
      failures++;
      $display("FAIL retry_writes: idx2 %0d idx3 %0d, required 3 and 0",
               wr_cnt[exp_addr(2) >> 2], wr_cnt[exp_addr(3) >> 2]);
    end
    corrupt_en = 1'b0;
  endtask

  task automatic test_bresp();
    bresp_en = 1'b1; bresp_addr = exp_addr(5);
    clear_log();
    pulse_start();
    wait_end("bresp");
    checks++;
    if ({error, err_code, err_idx} !== 6'b110101) begin
      failures++;
      $display("FAIL bresp_status: error,code,idx got %b required 110101", {error, err_code, err_idx});
    end
    checks++;
    if (rd_cnt[exp_addr(5) >> 2] != 0 || wr_cnt[exp_addr(6) >> 2] != 0) begin
      failures++;
      $display("FAIL bresp_noread: reads idx5 %0d writes idx6 %0d, required 0 and 0",
               rd_cnt[exp_addr(5) >> 2], wr_cnt[exp_addr(6) >> 2]);
    end
    bresp_en = 1'b0;
    clear_log();
    pulse_start();
    checks++;
    if ({error, err_code, err_idx} !== 6'b0) begin
      failures++;
      $display("FAIL rerun_clear: error,code,idx got %b required 0", {error, err_code, err_idx});
    end
    wait_end("rerun");
    checks++;
    if (done !== 1'b1 || wr_seq[0] !== exp_addr(0) || wr_n != 8) begin
      failures++;
      $display("FAIL rerun_done: done %b first %h writes %0d, required 1 10 8", done, wr_seq[0], wr_n);
    end
  endtask

  task automatic test_timeout();
    int n;
    int c;
    b_never = 1'b1;
    clear_log();
    pulse_start();
    for (c = 0; c < 50 && !bready; c++) @(negedge clk);
    n = 0;
    for (c = 0; c < 100 && !error; c++) begin
      if (bready) n++;
      @(negedge clk);
    end
    checks++;
    if (n != 16 || err_code !== 2'd3 || err_idx !== 3'd0) begin
      failures++;
      $display("FAIL timeout_code: bready cycles %0d code %0d idx %0d, required 16 3 0", n, err_code, err_idx);
    end
    checks++;
    if ({bready, awvalid, wvalid, arvalid, rready, busy} !== 6'b0) begin
      failures++;
      $display("FAIL timeout_abort: handshakes/busy got %b required 0", {bready, awvalid, wvalid, arvalid, rready, busy});
    end
    b_never = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid();
    int c;
    aw_delay = 4;
    clear_log();
    pulse_start();
    for (c = 0; c < 50 && !awvalid; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, error, err_code, err_idx, tbl_idx, awvalid, wvalid, bready, arvalid, rready,
         awaddr, araddr, wdata} !== 64'b0) begin
      failures++;
      $display("FAIL reset_mid: outputs got %h required 0",
               {busy, done, error, err_code, err_idx, tbl_idx, awvalid, wvalid, bready, arvalid, rready, awaddr, araddr, wdata});
    end
    rst = 1'b0;
    aw_delay = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aw_delay();
    test_retry();
    test_bresp();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
